// File: rtl/dotp_pkg.sv
// Shared types and constants for the dot-product sequencer.
// Saturating signed arithmetic is selected by defining DOTP_SAT_EN (see dotp_mac).
package dotp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    MAC     = 3'd3,
    DONE    = 3'd4
  } dotp_state_t;

  localparam int WORD_BYTES = 4;

  localparam logic [31:0] DOTP_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] DOTP_MIN = 32'h8000_0000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dotp_mac.sv
// Combinational multiply-accumulate step: acc + opa*opb.
// DOTP_SAT_EN selects signed operands with a clamping, sticky-saturating accumulator.
module dotp_mac
  import dotp_pkg::*;
(
  input  logic [31:0] acc,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        sat_in,
  output logic [31:0] acc_next,
  output logic        sat_out
);

`ifdef DOTP_SAT_EN
  logic signed [63:0] prod_s;
  logic        [65:0] sum_s;

  // Signed 64-bit product, 66-bit sum, clamp to the 32-bit signed range.
  always_comb begin
    prod_s   = $signed(opa) * $signed(opb);
    sum_s    = {{34{acc[31]}}, acc} + {{2{prod_s[63]}}, prod_s};
    acc_next = sum_s[31:0];
    sat_out  = 1'b0;
    if (sat_in) begin
      // once clamped, the accumulator holds its limit for the rest of the job
      acc_next = acc;
      sat_out  = 1'b1;
    end else if (!sum_s[65] && (|sum_s[64:31])) begin
      acc_next = DOTP_MAX;
      sat_out  = 1'b1;
    end else if (sum_s[65] && !(&sum_s[64:31])) begin
      acc_next = DOTP_MIN;
      sat_out  = 1'b1;
    end else begin
      acc_next = sum_s[31:0];
      sat_out  = 1'b0;
    end
  end
`else
  logic [31:0] prod_s;

  // Unsigned product truncated to 32 bits, modular accumulation.
  always_comb begin
    prod_s  = opa * opb;
    sat_out = sat_in;
    if (sat_in) begin
      acc_next = acc;
    end else begin
      acc_next = acc + prod_s;
    end
  end
`endif

endmodule

// File: rtl/dot_product_sequencer.sv
// Dot-product sequencer: fetches A/B word pairs over a request/grant port and accumulates.
// Arithmetic mode is chosen in dotp_mac by DOTP_SAT_EN; the port list is identical in both builds.
module dot_product_sequencer
  import dotp_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_a,
  input  logic [31:0]      base_b,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic             align_err,
  output logic [31:0]      result,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_gnt,
  input  logic [31:0]      mem_rdata
);

  dotp_state_t      state_r, state_s;
  logic [31:0]      ptr_a_r, ptr_b_r;
  logic [LEN_W-1:0] cnt_r;
  logic [31:0]      acc_r, opa_r, opb_r, result_r;
  logic             align_r, sat_r;
  logic [31:0]      acc_next_s;
  logic             sat_next_s;
  logic             bases_ok_s;
  logic             last_s;

  assign bases_ok_s = is_word_aligned(base_a) && is_word_aligned(base_b);
  assign last_s     = (cnt_r == LEN_W'(1));

  dotp_mac u_mac (
    .acc      (acc_r),
    .opa      (opa_r),
    .opb      (opb_r),
    .sat_in   (sat_r),
    .acc_next (acc_next_s),
    .sat_out  (sat_next_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && (!bases_ok_s || (length == '0))) begin
          state_s = DONE;
        end else if (start) begin
          state_s = FETCH_A;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH_A: begin
        if (mem_gnt) state_s = FETCH_B;
        else         state_s = FETCH_A;
      end
      FETCH_B: begin
        if (mem_gnt) state_s = MAC;
        else         state_s = FETCH_B;
      end
      MAC: begin
        if (last_s) state_s = DONE;
        else        state_s = FETCH_A;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath: pointers, counter, operands, accumulator and result.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_a_r  <= 32'd0;
      ptr_b_r  <= 32'd0;
      cnt_r    <= '0;
      acc_r    <= 32'd0;
      opa_r    <= 32'd0;
      opb_r    <= 32'd0;
      result_r <= 32'd0;
      align_r  <= 1'b0;
      sat_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !bases_ok_s) begin
            // misaligned job: flag only, result keeps its previous value
            align_r <= 1'b1;
          end else if (start) begin
            align_r  <= 1'b0;
            result_r <= 32'd0;
            acc_r    <= 32'd0;
            sat_r    <= 1'b0;
            ptr_a_r  <= base_a;
            ptr_b_r  <= base_b;
            cnt_r    <= length;
          end
        end
        FETCH_A: if (mem_gnt) opa_r <= mem_rdata;
        FETCH_B: if (mem_gnt) opb_r <= mem_rdata;
        MAC: begin
          acc_r   <= acc_next_s;
          sat_r   <= sat_next_s;
          ptr_a_r <= ptr_a_r + 32'(WORD_BYTES);
          ptr_b_r <= ptr_b_r + 32'(WORD_BYTES);
          cnt_r   <= cnt_r - LEN_W'(1);
          // publish on the way into DONE so result is valid alongside the done pulse
          if (last_s) result_r <= acc_next_s;
        end
        DONE:    align_r <= 1'b0;
        default: align_r <= 1'b0;
      endcase
    end
  end

  // Outputs decoded from registered state and registers only.
  always_comb begin
    busy      = (state_r != IDLE);
    done      = (state_r == DONE);
    align_err = (state_r == DONE) && align_r;
    mem_req   = (state_r == FETCH_A) || (state_r == FETCH_B);
    result    = result_r;
    case (state_r)
      FETCH_A: mem_addr = ptr_a_r;
      FETCH_B: mem_addr = ptr_b_r;
      default: mem_addr = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed, table-driven bench for dot_product_sequencer with a word-array memory model.
module tb_dot_product_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, busy, done, align_err, mem_req, mem_gnt;
  logic [31:0] base_a, base_b, result, mem_addr, mem_rdata;
  logic [7:0]  length;

  logic [31:0] mem [0:63];
  logic [31:0] addr_log [0:31];
  int          n_log, req_cycles;
  int          tests = 0, fails = 0;
  logic        prev_req = 1'b0, prev_gnt = 1'b1;
  logic [31:0] prev_addr = 32'd0;

  typedef struct {
    logic [31:0] ba;
    logic [31:0] bb;
    logic [7:0]  len;
    int          stall;
    logic [31:0] exp_res;
    int          exp_edges;
    logic        exp_align;
    int          exp_reqs;
  } vec_t;

  vec_t vecs [0:7];

  always #5 clk = ~clk;

  assign mem_rdata = mem_gnt ? mem[mem_addr[7:2]] : 32'hDEAD_BEEF;

  dot_product_sequencer #(.LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_a(base_a), .base_b(base_b),
    .length(length), .busy(busy), .done(done), .align_err(align_err), .result(result),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Request monitor: logs granted addresses and checks address stability across stalls.
  always @(negedge clk) begin
    if (mem_req) begin
      req_cycles++;
      if (prev_req && !prev_gnt) check("addr_stable", mem_addr, prev_addr);
      if (mem_gnt && n_log < 32) begin
        addr_log[n_log] = mem_addr;
        n_log++;
      end
    end
    prev_req  = mem_req;
    prev_gnt  = mem_gnt;
    prev_addr = mem_addr;
  end

  task automatic run_job(input logic [31:0] ba, input logic [31:0] bb, input logic [7:0] len,
                         input int stall, output int edges, output logic [31:0] res,
                         output logic aerr);
    int stall_cnt;
    stall_cnt  = 0;
    n_log      = 0;
    req_cycles = 0;
    base_a = ba; base_b = bb; length = len; start = 1'b1; mem_gnt = 1'b1;
    @(posedge clk);
    edges = 1;
    #1 start = 1'b0;
    while (!done && edges < 1000) begin
      if (mem_req && ((mem_addr - bb) < 32'(len) * 32'd4) && stall_cnt < stall) begin
        mem_gnt = 1'b0;
        stall_cnt++;
      end else begin
        mem_gnt = 1'b1;
        if (mem_req) stall_cnt = 0;
      end
      @(posedge clk);
      edges++;
      #1;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    res  = result;
    aerr = align_err;
    mem_gnt = 1'b1;
    @(posedge clk);
    #1 check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int          edges;
    logic [31:0] res;
    logic        aerr;
    logic [31:0] exp_seq [0:7];
    bit          found;

    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0] = 32'd5;   mem[1] = 32'd2;  mem[2] = 32'd34;   mem[3] = 32'd4;
    mem[4] = 32'd567; mem[5] = 32'd6;  mem[6] = 32'd1000; mem[7] = 32'd0;
    mem[8] = 32'd7;   mem[9] = 32'd9;
    mem[16] = 32'hFFFF_FFFF; mem[17] = 32'd2;
    mem[20] = 32'h7FFF_FFFF; mem[21] = 32'h7FFF_FFFF; mem[22] = 32'd2; mem[23] = 32'd2;
    mem[63] = 32'd3;
    exp_seq[0] = 32'h0; exp_seq[1] = 32'h10; exp_seq[2] = 32'h4; exp_seq[3] = 32'h14;
    exp_seq[4] = 32'h8; exp_seq[5] = 32'h18; exp_seq[6] = 32'hC; exp_seq[7] = 32'h1C;

    vecs[0] = '{32'h0, 32'h10, 8'd4, 0, 32'd36847, 13, 1'b0, 8};
    vecs[1] = '{32'h0, 32'h10, 8'd4, 2, 32'd36847, 21, 1'b0, 16};
    vecs[2] = '{32'h2, 32'h10, 8'd4, 0, 32'd36847, 1, 1'b1, 0};
    vecs[3] = '{32'h0, 32'h11, 8'd3, 0, 32'd36847, 1, 1'b1, 0};
    vecs[4] = '{32'h0, 32'h10, 8'd0, 0, 32'd0, 1, 1'b0, 0};
    vecs[5] = '{32'h40, 32'h44, 8'd1, 0, 32'hFFFF_FFFE, 4, 1'b0, 2};
`ifdef DOTP_SAT_EN
    vecs[6] = '{32'h50, 32'h58, 8'd2, 0, 32'h7FFF_FFFF, 7, 1'b0, 4};
`else
    vecs[6] = '{32'h50, 32'h58, 8'd2, 0, 32'hFFFF_FFFC, 7, 1'b0, 4};
`endif
    vecs[7] = '{32'hFFFF_FFFC, 32'h20, 8'd2, 0, 32'd66, 7, 1'b0, 4};

    reset = 1'b1; start = 1'b0; base_a = 32'd0; base_b = 32'd0; length = 8'd0; mem_gnt = 1'b1;
    n_log = 0; req_cycles = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_align", {31'd0, align_err}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i].ba, vecs[i].bb, vecs[i].len, vecs[i].stall, edges, res, aerr);
      check($sformatf("v%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("v%0d_edges", i), 32'(edges), 32'(vecs[i].exp_edges));
      check($sformatf("v%0d_align", i), {31'd0, aerr}, {31'd0, vecs[i].exp_align});
      check($sformatf("v%0d_req_cycles", i), 32'(req_cycles), 32'(vecs[i].exp_reqs));
      if (i == 0) begin
        for (int k = 0; k < 8; k++) check($sformatf("v0_addr%0d", k), addr_log[k], exp_seq[k]);
      end
      if (i == 7) check("wrap_addr", addr_log[2], 32'h0);
    end

    // Start while busy is ignored; reset during FETCH_B of element 2 aborts the job.
    n_log = 0;
    base_a = 32'h0; base_b = 32'h10; length = 8'd4; start = 1'b1; mem_gnt = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 base_a = 32'h40; base_b = 32'h44; length = 8'd1; start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (mem_req && mem_addr == 32'h14) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("busy_start_ignored", {31'd0, found}, 32'd1);
    check("busy_start_log", addr_log[2], 32'h4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_job(32'h0, 32'h10, 8'd4, 0, edges, res, aerr);
    check("post_rst_result", res, 32'd36847);
    check("post_rst_edges", 32'(edges), 32'd13);

    // Start held through the done cycle is ignored; accepted one cycle later.
    base_a = 32'h0; base_b = 32'h10; length = 8'd0; start = 1'b1;
    @(posedge clk);
    #1 check("b2b_done1", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    check("b2b_idle_busy", {31'd0, busy}, 32'd0);
    check("b2b_idle_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1 check("b2b_done2", {31'd0, done}, 32'd1);
    start = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
